// File: rtl/jogo_rodadas_controle.sv
// Moore control unit for the round-based memory game.
// Round N replays the first N+1 stored plays. The unit drives the datapath
// counters and the play register, detects button presses, and times out slow
// plays. Outputs are decoded from the state register alone.
module jogo_rodadas_controle #(
  parameter int TIMEOUT_CICLOS = 5000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada,
  input  logic       igual,
  input  logic       fimE,
  input  logic       fimL,
  output logic       zeraE,
  output logic       contaE,
  output logic       zeraL,
  output logic       contaL,
  output logic       zeraJ,
  output logic       registraJ,
  output logic       pronto,
  output logic       acertou,
  output logic       errou,
  output logic       timeout,
  output logic [3:0] db_estado
);

  localparam int TW = ($clog2(TIMEOUT_CICLOS) < 1) ? 1 : $clog2(TIMEOUT_CICLOS);

  // State values double as the 7-segment display codes.
  typedef enum logic [3:0] {
    INICIAL        = 4'h0,
    PREPARACAO     = 4'h1,
    INICIA_RODADA  = 4'h2,
    ESPERA         = 4'h3,
    REGISTRA       = 4'h4,
    COMPARACAO     = 4'h5,
    PROXIMA_JOGADA = 4'h6,
    PROXIMA_RODADA = 4'h7,
    FIM_ACERTOU    = 4'hA,
    FIM_TIMEOUT    = 4'hB,
    FIM_ERROU      = 4'hE
  } estado_t;

  estado_t       estado, proximo;
  logic          jogada_d;
  logic [TW-1:0] cont_t;
  logic          pulso, tfim;

  // A held button produces exactly one cycle of pulso.
  assign pulso = jogada & ~jogada_d;
  assign tfim  = (cont_t == TW'(TIMEOUT_CICLOS - 1));

  // Next-state selection; an unreachable encoding falls back to inicial.
  always_comb begin
    proximo = INICIAL;
    case (estado)
      INICIAL:        proximo = iniciar ? PREPARACAO : INICIAL;
      PREPARACAO:     proximo = INICIA_RODADA;
      INICIA_RODADA:  proximo = ESPERA;
      // A press in the same cycle as tfim still counts as a play.
      ESPERA:         proximo = pulso ? REGISTRA : (tfim ? FIM_TIMEOUT : ESPERA);
      REGISTRA:       proximo = COMPARACAO;
      COMPARACAO: begin
        if (!igual)     proximo = FIM_ERROU;
        else if (!fimE) proximo = PROXIMA_JOGADA;
        else if (!fimL) proximo = PROXIMA_RODADA;
        else            proximo = FIM_ACERTOU;
      end
      PROXIMA_JOGADA: proximo = ESPERA;
      PROXIMA_RODADA: proximo = INICIA_RODADA;
      FIM_ACERTOU:    proximo = iniciar ? PREPARACAO : FIM_ACERTOU;
      FIM_TIMEOUT:    proximo = iniciar ? PREPARACAO : FIM_TIMEOUT;
      FIM_ERROU:      proximo = iniciar ? PREPARACAO : FIM_ERROU;
      default:        proximo = INICIAL;
    endcase
  end

  // State, button history and play timer. The timer only runs while the FSM
  // stays in espera, so every entry to espera starts again from zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado   <= INICIAL;
      jogada_d <= 1'b0;
      cont_t   <= '0;
    end else begin
      estado   <= proximo;
      jogada_d <= jogada;
      if (estado == ESPERA && proximo == ESPERA) cont_t <= cont_t + TW'(1);
      else                                       cont_t <= '0;
    end
  end

  // Moore output decode; reset reaches the outputs without a clock edge.
  always_comb begin
    zeraE     = (estado == INICIAL) || (estado == PREPARACAO) || (estado == INICIA_RODADA);
    zeraL     = (estado == INICIAL) || (estado == PREPARACAO);
    zeraJ     = (estado == INICIAL) || (estado == PREPARACAO) || (estado == INICIA_RODADA);
    registraJ = (estado == REGISTRA);
    contaE    = (estado == PROXIMA_JOGADA);
    contaL    = (estado == PROXIMA_RODADA);
    acertou   = (estado == FIM_ACERTOU);
    errou     = (estado == FIM_ERROU);
    timeout   = (estado == FIM_TIMEOUT);
    pronto    = acertou | errou | timeout;
    case (estado)
      INICIAL, PREPARACAO, INICIA_RODADA, ESPERA, REGISTRA, COMPARACAO,
      PROXIMA_JOGADA, PROXIMA_RODADA, FIM_ACERTOU, FIM_TIMEOUT, FIM_ERROU:
        db_estado = estado;
      default: db_estado = 4'hF;
    endcase
  end

endmodule

// File: tb/tb_jogo_rodadas_controle.sv
// Bench for jogo_rodadas_controle: directed scenarios plus randomized games.
// Expected state codes come from a game-level script (round r replays plays
// 0..r) and the output set is derived from each display code.
module tb_jogo_rodadas_controle;
  localparam int TO = 8;
  localparam logic [3:0] C_INI = 4'h0, C_PREP = 4'h1, C_ROD = 4'h2, C_ESP = 4'h3,
                         C_REG = 4'h4, C_CMP = 4'h5, C_PJ = 4'h6, C_PR = 4'h7,
                         C_WIN = 4'hA, C_TO = 4'hB, C_ERR = 4'hE;

  logic clock = 1'b0;
  logic reset, iniciar, jogada, igual, fimE, fimL;
  logic zeraE, contaE, zeraL, contaL, zeraJ, registraJ, pronto, acertou, errou, timeout;
  logic [3:0] db_estado;

  int vectors = 0, miscompares = 0;
  int n_contaE = 0, n_contaL = 0, n_regJ = 0;

  jogo_rodadas_controle #(.TIMEOUT_CICLOS(TO)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .jogada(jogada),
    .igual(igual), .fimE(fimE), .fimL(fimL),
    .zeraE(zeraE), .contaE(contaE), .zeraL(zeraL), .contaL(contaL),
    .zeraJ(zeraJ), .registraJ(registraJ), .pronto(pronto), .acertou(acertou),
    .errou(errou), .timeout(timeout), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  wire [13:0] obs = {db_estado, zeraE, contaE, zeraL, contaL, zeraJ, registraJ,
                     pronto, acertou, errou, timeout};

  // Output set implied by a display code.
  function automatic logic [13:0] esperado(input logic [3:0] c);
    return {c, c inside {C_INI, C_PREP, C_ROD}, c == C_PJ, c inside {C_INI, C_PREP},
            c == C_PR, c inside {C_INI, C_PREP, C_ROD}, c == C_REG,
            c inside {C_WIN, C_TO, C_ERR}, c == C_WIN, c == C_ERR, c == C_TO};
  endfunction

  task automatic chk(input string tag, input logic [3:0] code);
    vectors++;
    assert (obs === esperado(code)) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, esperado(code));
    end
  endtask

  task automatic chk_int(input string tag, input int got, input int exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    if (contaE) n_contaE++;
    if (contaL) n_contaL++;
    if (registraJ) n_regJ++;
  endtask

  task automatic tick_chk(input string tag, input logic [3:0] code);
    tick();
    chk(tag, code);
  endtask

  task automatic start_game();
    n_contaE = 0; n_contaL = 0; n_regJ = 0;
    iniciar = 1'b1;
    tick_chk("preparacao", C_PREP);
    iniciar = 1'b0;
    tick_chk("inicia_rodada", C_ROD);
    tick_chk("espera", C_ESP);
  endtask

  // One play p of round r in an R-round game, after w idle cycles in espera,
  // button held for h edges.
  task automatic play(input int r, input int p, input int nr, input logic ok,
                      input int w, input int h, output logic [3:0] res);
    igual = ok; fimE = (p == r); fimL = (r == nr - 1);
    repeat (w) tick_chk("espera_idle", C_ESP);
    jogada = 1'b1;
    tick_chk("registra", C_REG);
    if (h == 1) jogada = 1'b0;
    tick_chk("comparacao", C_CMP);
    if (h == 2) jogada = 1'b0;
    res = !ok ? C_ERR : (p != r) ? C_PJ : (r != nr - 1) ? C_PR : C_WIN;
    tick_chk("resultado", res);
    jogada = 1'b0;
    if (res == C_PJ) tick_chk("volta_espera", C_ESP);
    if (res == C_PR) begin
      tick_chk("nova_rodada", C_ROD);
      tick_chk("espera_rodada", C_ESP);
    end
  endtask

  task automatic wait_timeout();
    repeat (TO - 1) tick_chk("espera_ate_tfim", C_ESP);
    tick_chk("fim_timeout", C_TO);
  endtask

  // mode 0 win, 1 wrong play at (fr,fp), 2 timeout at (fr,fp).
  task automatic game(input int nr, input int mode, input int fr, input int fp,
                      input int wfix);
    logic [3:0] res;
    int w;
    start_game();
    for (int r = 0; r < nr; r++) begin
      for (int p = 0; p <= r; p++) begin
        if (mode == 2 && r == fr && p == fp) begin
          wait_timeout();
          return;
        end
        w = (wfix >= 0) ? wfix : int'($urandom_range(0, TO - 1));
        play(r, p, nr, !(mode == 1 && r == fr && p == fp), w,
             int'($urandom_range(1, 3)), res);
        if (res inside {C_WIN, C_ERR}) begin
          if (res == C_WIN) begin
            chk_int("contaL_pulsos", n_contaL, nr - 1);
            chk_int("contaE_pulsos", n_contaE, nr * (nr - 1) / 2);
          end
          tick_chk("fim_hold", res);
          return;
        end
      end
    end
  endtask

  initial begin
    int nr, mode, fr, fp;
    reset = 1'b1; iniciar = 1'b0; jogada = 1'b0; igual = 1'b0; fimE = 1'b0; fimL = 1'b0;
    #2 chk("reset_async", C_INI);
    #11 reset = 1'b0;
    repeat (20) tick_chk("idle_inicial", C_INI);

    // Full 4-round win; the press lands on the tfim cycle every time.
    game(4, 0, 0, 0, TO - 1);
    // Wrong second play of round 2 (round index 1), then restart from fim_errou.
    game(3, 1, 1, 1, -1);
    iniciar = 1'b1;
    tick_chk("restart_apos_erro", C_PREP);
    iniciar = 1'b0;
    tick_chk("inicia_rodada", C_ROD);
    tick_chk("espera", C_ESP);
    wait_timeout();
    tick_chk("timeout_hold", C_TO);

    // Button held for 50 cycles: one registra, then timeout for lack of a new press.
    start_game();
    igual = 1'b1; fimE = 1'b0; fimL = 1'b0; jogada = 1'b1;
    repeat (50) tick();
    chk_int("registraJ_unico", n_regJ, 1);
    chk("hold_termina_timeout", C_TO);
    jogada = 1'b0;

    // Randomized games.
    for (int g = 0; g < 10; g++) begin
      nr = int'($urandom_range(1, 4));
      mode = int'($urandom_range(0, 2));
      fr = int'($urandom_range(0, nr - 1));
      fp = int'($urandom_range(0, fr));
      game(nr, mode, fr, fp, -1);
    end

    // Asynchronous reset during comparacao.
    start_game();
    igual = 1'b1; fimE = 1'b0; fimL = 1'b0; jogada = 1'b1;
    tick_chk("registra", C_REG);
    jogada = 1'b0;
    tick_chk("comparacao", C_CMP);
    #2 reset = 1'b1;
    #1 chk("reset_meio_jogo", C_INI);
    #2 reset = 1'b0;
    tick_chk("apos_reset", C_INI);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/jogo_rodadas_controle.md
# jogo_rodadas_controle

Moore control unit for the round-based memory game: each round N the player repeats the first N+1 stored plays, so the sequence grows by one play per round. The block sequences the existing datapath (address counter, round counter, play register, comparator). It detects button presses, enforces a per-play timeout and reports win, loss or timeout. It sits beside the datapath in the top-level game circuit and replaces the single-pass compare controller.

## Interface
- TIMEOUT_CICLOS, default 5000: clock cycles allowed in espera before timeout; legal range ≥2.
- clock  in  1  system clock, all state on rising edge.
- reset  in  1  reset, asynchronous, active-high.
- iniciar  in  1  level; starts a game from inicial or from any final state.
- jogada  in  1  level; OR of all player buttons, from the datapath.
- igual  in  1  registered play equals the memory word at the current address.
- fimE  in  1  address counter equals the round counter (last play of this round).
- fimL  in  1  round counter at its last value (last round).
- zeraE  out  1  clear address counter.
- contaE  out  1  increment address counter.
- zeraL  out  1  clear round counter.
- contaL  out  1  increment round counter.
- zeraJ  out  1  clear play register.
- registraJ  out  1  load play register.
- pronto  out  1  game over (any final state).
- acertou  out  1  game won.
- errou  out  1  wrong play.
- timeout  out  1  play not made in time.
- db_estado  out  4  state code for the 7-segment display.

## Operation
- States and db_estado codes: inicial 0, preparacao 1, inicia_rodada 2, espera 3, registra 4, comparacao 5, proxima_jogada 6, proxima_rodada 7, fim_acertou A, fim_timeout B, fim_errou E. An unreachable encoding goes to inicial on the next edge and shows F while present.
- Edge detect: internal jogada_d <= jogada every cycle in every state; pulso = jogada & ~jogada_d. Only pulso advances the FSM. A held button gives one pulse.
- Timeout counter: internal, width ceil(log2(TIMEOUT_CICLOS)). Held at 0 in every state except espera; increments each cycle in espera. tfim = (count == TIMEOUT_CICLOS-1).
- Transitions:
  - inicial: iniciar -> preparacao, else stay.
  - preparacao -> inicia_rodada.
  - inicia_rodada -> espera.
  - espera: pulso -> registra; else tfim -> fim_timeout; else stay. pulso and tfim in the same cycle: pulso wins.
  - registra -> comparacao.
  - comparacao: !igual -> fim_errou; igual & !fimE -> proxima_jogada; igual & fimE & !fimL -> proxima_rodada; igual & fimE & fimL -> fim_acertou.
  - proxima_jogada -> espera.
  - proxima_rodada -> inicia_rodada.
  - fim_acertou / fim_errou / fim_timeout: iniciar -> preparacao, else hold.
- Outputs, decoded from state only:
  - zeraE = inicial | preparacao | inicia_rodada.
  - zeraL = inicial | preparacao.
  - zeraJ = inicial | preparacao | inicia_rodada.
  - registraJ = registra.
  - contaE = proxima_jogada.
  - contaL = proxima_rodada.
  - pronto = any final state.
  - acertou = fim_acertou.
  - errou = fim_errou.
  - timeout = fim_timeout.
  - Outputs are mutually consistent: never acertou together with errou or timeout.

## Timing
- Reset (async) state: inicial; jogada_d=0; timeout counter=0.
- Reset output values: zeraE=zeraL=zeraJ=1, all other outputs 0, db_estado=0.
- Reset mid-game forces inicial immediately, without waiting for a clock edge.
- iniciar sampled at edge k moves to preparacao at k. The first espera is reached at k+2.
- Play latency: jogada rises before edge k (with jogada_d=0) -> registra at k, comparacao at k+1, next state at k+2.
- Timeout: entering espera at edge k with no press -> fim_timeout at edge k+TIMEOUT_CICLOS.
- The timeout counter restarts from 0 on every entry to espera.
- Datapath contract: igual, fimE and fimL must be valid during comparacao (one cycle after registraJ).
- fimE/fimL are ignored in all other states.

## Test plan
- Reset then idle, iniciar=0 for 20 cycles -> stays in inicial (db_estado=0), pronto=0, zeraE=zeraL=1.
- Full win, 4 rounds (fimL at round 3), all plays correct with igual=1 -> rounds consume 1,2,3,4 plays. contaL pulses 3 times and contaE pulses 6 times. Ends in fim_acertou, db_estado=A, pronto=1, acertou=1.
- Round 2, second play with igual=0 -> fim_errou, db_estado=E, errou=1, acertou=0. iniciar then gives preparacao (db 1) on the next edge.
- TIMEOUT_CICLOS=8, no press after entering espera -> still in espera after 7 edges, fim_timeout (db B, timeout=1) at the 8th.
- Button held high for 50 cycles -> exactly one registra. A second play needs release and re-press. A press coinciding with tfim -> registra, not timeout.
- Reset asserted asynchronously during comparacao -> db_estado=0 before the next clock edge.
